// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants and tag payload for the shared pipelined-adder arbiter and its adder wrapper.
package adder_share_arbiter_pkg;

  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned ADD_LATENCY = 6;
  localparam int unsigned NUM_REQ_DEF = 4;

  // Wide enough for up to 8 requesters; narrower IDs are zero-extended into it.
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response/adder bus between the clients, the shared adder and the arbiter.
interface adder_share_arbiter_if
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LATENCY = ADD_LATENCY
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1) + 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_ready;
  logic                      add_ce;
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic [DATA_W-1:0]         add_s;
  logic [CNT_W-1:0]          inflight;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, add_s,
    output req_ready, rsp_valid, rsp_id, rsp_data, add_ce, add_a, add_b, inflight
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, add_s,
    input  req_ready, rsp_valid, rsp_id, rsp_data, add_ce, add_a, add_b, inflight
  );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin priority select; the pointer holds the index where the next search starts.
module adder_share_arbiter_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    req_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_vld_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin : search
    logic [ID_W-1:0] idx;
    logic            found;
    found     = 1'b0;
    idx       = '0;
    gnt_id_o  = '0;
    gnt_o     = '0;
    ptr_d     = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt_id_o = idx;
      end
    end
    gnt_vld_o = found & en_i;
    if (gnt_vld_o) begin
      gnt_o[gnt_id_o] = 1'b1;
      // Next search begins just after the winner, wrapping at N.
      ptr_d = (gnt_id_o == ID_W'(N - 1)) ? '0 : gnt_id_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one CE-gated pipelined adder between NUM_REQ requesters; an ID tag pipeline
// runs in lockstep with the adder to route each sum back to its owner.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LATENCY = ADD_LATENCY
) (
  input  logic                  clk,
  input  logic                  resetn,
  adder_share_arbiter_if.master bus
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1) + 1;

  logic               stall;
  logic               arb_en;
  logic               grant_vld;
  logic               rsp_hs;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  tag_t               tag_q [LATENCY];
  tag_t               tag_d [LATENCY];
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  assign stall  = tag_q[LATENCY-1].valid & ~bus.rsp_ready;
  assign rsp_hs = tag_q[LATENCY-1].valid & bus.rsp_ready;
  // Grants are suppressed while stalled and while reset is held.
  assign arb_en = ~stall & resetn;

  adder_share_arbiter_rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .req_i     (bus.req_valid),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (grant_vld)
  );

  // Operand mux; no grant issues a zero bubble.
  always_comb begin
    bus.add_a = '0;
    bus.add_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bus.add_a = bus.req_a[i*DATA_W +: DATA_W];
        bus.add_b = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    tag_d[0] = tag_t'{valid: grant_vld, id: TAG_ID_W'(gnt_id)};
    for (int unsigned i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else if (!stall) begin
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({grant_vld, rsp_hs})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) inflight_q <= '0;
    else         inflight_q <= inflight_d;
  end

  assign bus.req_ready = gnt;
  assign bus.add_ce    = ~stall;
  assign bus.rsp_valid = tag_q[LATENCY-1].valid;
  assign bus.rsp_id    = ID_W'(tag_q[LATENCY-1].id);
  assign bus.rsp_data  = bus.add_s;
  assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed plus random bench for adder_share_arbiter against a queue-based reference model.
module tb_adder_share_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned LAT = 6;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(N), .ID_W(IDW), .DATA_W(DW), .LATENCY(LAT)) bus ();

  adder_share_arbiter #(.NUM_REQ(N), .ID_W(IDW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Shared adder stand-in: CE-gated, LAT stages.
  logic [DW-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    if (bus.add_ce) begin
      pipe[0] <= bus.add_a + bus.add_b;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.add_s = pipe[LAT-1];

  // Reference: in-order queue of outstanding ops, each counting the CE edges it has seen.
  typedef struct {
    int            id;
    logic [DW-1:0] sum;
    int            age;
  } op_t;

  op_t           q[$];
  int            start_idx;
  int            checks;
  int            failures;
  logic [DW-1:0] op_a [N];
  logic [DW-1:0] op_b [N];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = {$urandom, $urandom};
      op_b[i] = {$urandom, $urandom};
    end
  endtask

  // One clock: drive at negedge, check shortly after, advance the model at posedge.
  task automatic cycle(input logic [N-1:0] v, input logic rr, input logic rst);
    int         winner;
    int         c;
    logic       head_v;
    logic       stall;
    logic [N-1:0] exp_rdy;
    op_t        e;
    @(negedge clk);
    resetn        = rst;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = op_a[i];
      bus.req_b[i*DW +: DW] = op_b[i];
    end
    if (!rst) begin
      q.delete();
      start_idx = 0;
    end
    head_v  = (q.size() > 0) && (q[0].age == LAT);
    stall   = head_v && !rr;
    winner  = -1;
    exp_rdy = '0;
    if (rst && !stall) begin
      for (int k = 0; k < N; k++) begin
        c = (start_idx + k) % N;
        if (winner < 0 && v[c]) winner = c;
      end
    end
    if (winner >= 0) exp_rdy[winner] = 1'b1;
    #1;
    chk("req_ready", DW'(bus.req_ready), DW'(exp_rdy));
    chk("add_ce",    DW'(bus.add_ce),    DW'(!stall));
    chk("rsp_valid", DW'(bus.rsp_valid), DW'(head_v));
    if (head_v) begin
      chk("rsp_id",   DW'(bus.rsp_id), DW'(q[0].id));
      chk("rsp_data", bus.rsp_data,    q[0].sum);
    end
    chk("add_a",    bus.add_a, (winner >= 0) ? op_a[winner] : '0);
    chk("add_b",    bus.add_b, (winner >= 0) ? op_b[winner] : '0);
    chk("inflight", DW'(bus.inflight), DW'(q.size()));
    @(posedge clk);
    if (rst) begin
      if (head_v && rr) void'(q.pop_front());
      if (!stall) begin
        for (int i = 0; i < q.size(); i++) begin
          e = q[i];
          e.age++;
          q[i] = e;
        end
      end
      if (winner >= 0) begin
        e.id  = winner;
        e.sum = op_a[winner] + op_b[winner];
        e.age = 1;
        q.push_back(e);
        start_idx = (winner + 1) % N;
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    start_idx     = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset state, with requests present to prove no grant leaks out.
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);

    // Single request: 5 + -7.
    op_a[0] = 64'd5;
    op_b[0] = 64'hFFFF_FFFF_FFFF_FFF9;
    cycle(4'b0001, 1'b1, 1'b1);
    repeat (8) cycle(4'b0000, 1'b1, 1'b1);

    // Fairness with all requesters active.
    repeat (8) begin
      new_ops();
      cycle(4'b1111, 1'b1, 1'b1);
    end
    repeat (8) cycle(4'b0000, 1'b1, 1'b1);

    // Wrap-around sums.
    op_a[1] = 64'h7FFF_FFFF_FFFF_FFFF;
    op_b[1] = 64'd1;
    op_a[2] = '1;
    op_b[2] = '1;
    cycle(4'b0010, 1'b1, 1'b1);
    cycle(4'b0100, 1'b1, 1'b1);
    repeat (8) cycle(4'b0000, 1'b1, 1'b1);

    // Back-pressure: first result lands on the first of four stalled cycles.
    new_ops();
    repeat (3) cycle(4'b0001, 1'b1, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1, 1'b1);
    repeat (4) cycle(4'b1111, 1'b0, 1'b1);
    repeat (8) cycle(4'b0000, 1'b1, 1'b1);

    // Reset mid-flight, then a fresh request.
    repeat (4) begin
      new_ops();
      cycle(4'b1111, 1'b1, 1'b1);
    end
    cycle(4'b1111, 1'b1, 1'b0);
    repeat (8) cycle(4'b0000, 1'b1, 1'b1);
    new_ops();
    cycle(4'b0001, 1'b1, 1'b1);
    repeat (8) cycle(4'b0000, 1'b1, 1'b1);

    // Sparse priority: 2 alone, then 1 and 3 together.
    new_ops();
    cycle(4'b0100, 1'b1, 1'b1);
    cycle(4'b1010, 1'b1, 1'b1);
    cycle(4'b1010, 1'b1, 1'b1);
    repeat (8) cycle(4'b0000, 1'b1, 1'b1);

    // Random traffic with random back-pressure.
    repeat (300) begin
      new_ops();
      cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    end
    repeat (12) cycle(4'b0000, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
